// File: rtl/wb_trace_serializer.sv
// Captures one selected writeback trace field per retired instruction into a FIFO
// and streams each buffered word MSB-first as eight 4-bit nibbles on the debug pins.
module wb_trace_serializer #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] debug_wb_pc,
    input  logic [31:0] debug_wb_instr,
    input  logic [31:0] debug_wb_rf_wdata,
    input  logic [1:0]  mode,
    output logic [3:0]  data,
    output logic        data_valid,
    output logic        data_sof,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   last_pc_q, last_pc_d;
    logic [1:0]    mode_q, mode_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [31:0]   sr_q, sr_d;
    logic [2:0]    nib_idx_q, nib_idx_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          overflow_q, overflow_d;
    logic [3:0]    data_q, data_d;
    logic          data_valid_q, data_valid_d;
    logic          data_sof_q, data_sof_d;

    logic          wb_event;
    logic          flush;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic [AW-1:0] wr_addr;
    logic [31:0]   field;

    always_comb begin
        wb_event  = (debug_wb_pc != last_pc_q) && (debug_wb_pc != '0);
        flush     = (mode != mode_q);
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        last_pc_d = debug_wb_pc;
        mode_d    = mode;
        case (mode)
            2'd0:    field = debug_wb_pc;
            2'd1:    field = debug_wb_instr;
            default: field = debug_wb_rf_wdata;
        endcase
    end

    // Transmit FSM: a mode change aborts whatever word is on the pins.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        nib_idx_d = nib_idx_q;
        div_cnt_d = div_cnt_q;
        pop       = 1'b0;
        if (flush) begin
            state_d   = IDLE;
            nib_idx_d = '0;
            div_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_d   = SHIFT;
                        sr_d      = mem_q[rd_ptr_q[AW-1:0]];
                        nib_idx_d = '0;
                        div_cnt_d = '0;
                    end
                end
                SHIFT: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d = '0;
                        if (nib_idx_q == 3'd7) begin
                            nib_idx_d = '0;
                            if (!empty) begin
                                pop  = 1'b1;
                                sr_d = mem_q[rd_ptr_q[AW-1:0]];
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            nib_idx_d = nib_idx_q + 3'd1;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Flush happens before the push so a same-cycle event lands in the emptied FIFO.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        wr_addr    = flush ? '0 : wr_ptr_q[AW-1:0];
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            overflow_d = 1'b0;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wb_event && (mode != 2'd3)) begin
            if (flush || !full || pop) begin
                push = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (push) begin
            wr_ptr_d = wr_ptr_d + 1'b1;
        end
    end

    always_comb begin
        data_valid_d = (state_d == SHIFT);
        data_sof_d   = (state_d == SHIFT) && (nib_idx_d == 3'd0);
        data_d       = (state_d == SHIFT) ? sr_d[{~nib_idx_d, 2'b00} +: 4] : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_pc_q    <= '0;
            mode_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            sr_q         <= '0;
            nib_idx_q    <= '0;
            div_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            data_sof_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_pc_q    <= last_pc_d;
            mode_q       <= mode_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            sr_q         <= sr_d;
            nib_idx_q    <= nib_idx_d;
            div_cnt_q    <= div_cnt_d;
            overflow_q   <= overflow_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            data_sof_q   <= data_sof_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_addr] <= field;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign data_sof   = data_sof_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_wb_trace_serializer.sv
// Bench for wb_trace_serializer: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the trace stream.
module tb_wb_trace_serializer;
    localparam int DEPTH    = 4;
    localparam int DIV      = 4;
    localparam int WORD_CYC = 8 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  data;
    logic        data_valid;
    logic        data_sof;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int sof_cnt  = 0;
    int valid_cnt = 0;
    bit sof_prev = 1'b0;

    wb_trace_serializer #(.FIFO_DEPTH(DEPTH), .DIV(DIV)) dut (
        .clk              (clk),
        .rst              (rst),
        .debug_wb_pc      (pc),
        .debug_wb_instr   (instr),
        .debug_wb_rf_wdata(wdata),
        .mode             (mode),
        .data             (data),
        .data_valid       (data_valid),
        .data_sof         (data_sof),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: a queue of captured words and one word on the pins with a linear cycle position.
    logic [31:0] m_q[$];
    logic [31:0] m_cur = '0;
    logic [31:0] m_last_pc = '0;
    logic [1:0]  m_mode_prev = 2'd0;
    bit          m_busy = 1'b0;
    bit          m_ovf = 1'b0;
    int          m_pos = 0;

    always @(posedge clk) begin
        logic [31:0] fld;
        bit ev, pop, flush;
        if (rst) begin
            m_q.delete();
            m_busy = 1'b0; m_ovf = 1'b0; m_pos = 0;
            m_last_pc = '0; m_mode_prev = 2'd0;
        end else begin
            flush = (mode != m_mode_prev);
            m_mode_prev = mode;
            ev = (pc != m_last_pc) && (pc != 0);
            m_last_pc = pc;
            fld = (mode == 2'd0) ? pc : (mode == 2'd1) ? instr : wdata;
            pop = 1'b0;
            if (flush) begin
                m_q.delete();
                m_busy = 1'b0;
                m_ovf = 1'b0;
            end else if (!m_busy || m_pos == WORD_CYC - 1) begin
                if (m_q.size() > 0) pop = 1'b1;
                else m_busy = 1'b0;
            end else begin
                m_pos++;
            end
            if (ev && mode != 2'd3) begin
                if (m_q.size() == DEPTH && !pop) m_ovf = 1'b1;
                else m_q.push_back(fld);
            end
            if (pop) begin
                m_cur = m_q.pop_front();
                m_busy = 1'b1;
                m_pos = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] sh;
        if (chk_en) begin
            sh = m_cur >> (28 - 4 * (m_pos / DIV));
            chk("data", {28'd0, data}, m_busy ? {28'd0, sh[3:0]} : 32'd0);
            chk("data_valid", {31'd0, data_valid}, {31'd0, m_busy});
            chk("data_sof", {31'd0, data_sof}, {31'd0, m_busy && (m_pos < DIV)});
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        end
    end

    always @(negedge clk) begin
        if (data_sof === 1'b1 && !sof_prev) sof_cnt++;
        if (data_valid === 1'b1) valid_cnt++;
        sof_prev = (data_sof === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for a start-of-frame then samples one nibble per DIV cycles.
    task automatic expect_word(input string name, input logic [31:0] w);
        int k;
        logic [31:0] got;
        k = 0;
        got = '0;
        while (data_sof !== 1'b1 && k < 300) begin
            tick(1);
            k++;
        end
        chk({name, "_start"}, {31'd0, data_sof}, 32'd1);
        if (data_sof === 1'b1) begin
            for (int i = 0; i < 8; i++) begin
                got = {got[27:0], data};
                if (i < 7) tick(DIV);
            end
            chk(name, got, w);
        end
    endtask

    initial begin
        tick(3);
        chk_en = 1'b1;
        rst = 1'b0;
        tick(1);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_data", {28'd0, data}, 32'd0);
        chk("rst_sof", {31'd0, data_sof}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);

        // First retirement after reset: latency, nibble order and hold time.
        pc = 32'hBFC0_0000;
        tick(1);
        chk("A_lat_valid", {31'd0, data_valid}, 32'd0);
        tick(1);
        chk("A_nib0", {28'd0, data}, 32'hB);
        chk("A_sof0", {31'd0, data_sof}, 32'd1);
        tick(3);
        chk("A_sof_last", {31'd0, data_sof}, 32'd1);
        tick(1);
        chk("A_nib1", {28'd0, data}, 32'hF);
        chk("A_sof_off", {31'd0, data_sof}, 32'd0);
        tick(27);
        chk("A_valid_end", {31'd0, data_valid}, 32'd1);
        tick(1);
        chk("A_valid_fall", {31'd0, data_valid}, 32'd0);
        tick(4);

        mode = 2'd1;
        tick(2);
        instr = 32'h3C08_A000;
        pc = 32'h0000_1000;
        expect_word("B_instr", 32'h3C08_A000);
        tick(40);
        mode = 2'd2;
        tick(2);
        wdata = 32'h1234_5678;
        pc = 32'h0000_1004;
        expect_word("B_wdata", 32'h1234_5678);
        tick(40);

        // Six retirements back to back into a four-deep FIFO.
        mode = 2'd0;
        tick(2);
        sof_cnt = 0;
        valid_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            pc = 32'h0000_2000 + 32'(4 * i);
            tick(1);
        end
        tick(5 * WORD_CYC + 10);
        chk("C_words", 32'(sof_cnt), 32'd5);
        chk("C_valid_cycles", 32'(valid_cnt), 32'd160);
        chk("C_ovf", {31'd0, overflow}, 32'd1);

        sof_cnt = 0;
        pc = 32'h8000_0100;
        tick(20);
        pc = 32'h8000_0104;
        tick(81);
        chk("D_words", 32'(sof_cnt), 32'd2);
        chk("D_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Mode change while a word is mid-flight with two more queued.
        pc = 32'h1234_5670; tick(1);
        pc = 32'h1234_5674; tick(1);
        pc = 32'h1234_5678; tick(1);
        tick(11);
        chk("E_nib3", {28'd0, data}, 32'h4);
        mode = 2'd1;
        instr = 32'hCAFE_F00D;
        pc = 32'h9000_0000;
        tick(1);
        chk("E_valid_off", {31'd0, data_valid}, 32'd0);
        chk("E_ovf_clr", {31'd0, overflow}, 32'd0);
        sof_cnt = 0;
        expect_word("E_instr", 32'hCAFE_F00D);
        tick(40);
        chk("E_words", 32'(sof_cnt), 32'd1);

        mode = 2'd3;
        tick(2);
        valid_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            pc = 32'h0000_4000 + 32'(4 * i);
            tick(1);
        end
        tick(20);
        chk("F_disabled", 32'(valid_cnt), 32'd0);
        mode = 2'd0;
        tick(2);
        sof_cnt = 0;
        pc = 32'h0000_5550;
        expect_word("F_pc", 32'h0000_5550);
        tick(40);
        chk("F_words", 32'(sof_cnt), 32'd1);

        // Reset in the middle of a word.
        pc = 32'h0000_6000;
        tick(10);
        chk("G_busy", {31'd0, data_valid}, 32'd1);
        rst = 1'b1;
        pc = '0;
        tick(1);
        chk("G_rst_valid", {31'd0, data_valid}, 32'd0);
        rst = 1'b0;
        tick(5);
        chk("G_no_resume", {31'd0, data_valid}, 32'd0);

        for (int c = 0; c < 3000; c++) begin
            instr = $urandom;
            wdata = $urandom;
            case ($urandom_range(0, 5))
                0: pc = $urandom;
                1: pc = pc + 32'd4;
                2: pc = ($urandom_range(0, 7) == 0) ? 32'd0 : pc;
                default: ;
            endcase
            if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(6 * WORD_CYC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
